// File: rtl/aes_enc_round_iter.sv
// Iterative AES-128 encryption datapath: initial AddRoundKey on accept, then one
// full round per clock; round keys and S-box lookups come from external ports.
module aes_enc_round_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic [127:0] sub_in,
  input  logic [127:0] sub_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t       state;
  logic [3:0]   rnd;
  logic [127:0] st;
  logic [127:0] sr;
  logic [127:0] mc;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = a[31:24];
    a1 = a[23:16];
    a2 = a[15:8];
    a3 = a[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  // Row r of output column c comes from input column (c+r) mod 4, same row.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127 - 32*c - 8*r -: 8] = s[127 - 32*((c + r) % 4) - 8*r -: 8];
      end
    end
    return o;
  endfunction

  always_comb begin
    sr = shift_rows(sub_out);
    mc = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      mc[127 - 32*c -: 32] = mix_col(sr[127 - 32*c -: 32]);
    end
  end

  assign in_ready = (state == IDLE) && !rst;
  assign rk_idx   = (state == ROUND) ? rnd : '0;
  assign sub_in   = st;
  assign ct       = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rnd       <= '0;
      st        <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st    <= pt ^ rk;
            rnd   <= 4'd1;
            state <= ROUND;
          end
        end
        ROUND: begin
          if (rnd == 4'd10) begin
            st        <= sr ^ rk;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            st  <= mc ^ rk;
            rnd <= rnd + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_enc_round_iter.sv
// Self-checking bench: models the key-schedule store and forward S-box array,
// and compares the DUT against a byte-array AES-128 reference.
module tb_aes_enc_round_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] pt;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic [127:0] sub_in;
  logic [127:0] sub_out;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ct;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sbox [0:255];
  logic [127:0] rks  [0:10];

  aes_enc_round_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pt(pt),
    .rk_idx(rk_idx), .rk(rk), .sub_in(sub_in), .sub_out(sub_out),
    .out_valid(out_valid), .out_ready(out_ready), .ct(ct)
  );

  always #5 clk = ~clk;

  always_comb begin
    rk = '0;
    if (rk_idx <= 4'd10) rk = rks[rk_idx];
  end

  always_comb begin
    sub_out = '0;
    for (int k = 0; k < 16; k++) sub_out[127 - 8*k -: 8] = sbox[sub_in[127 - 8*k -: 8]];
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse, then the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // State after nr rounds; state bytes indexed 4*col+row.
  function automatic logic [127:0] aes_ref(input logic [127:0] p, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] m [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
    logic [127:0] o;
    for (int k = 0; k < 16; k++) s[k] = p[127 - 8*k -: 8] ^ rks[0][127 - 8*k -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int k = 0; k < 16; k++) s[k] = sbox[s[k]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[4*c + w] = s[4*((c + w) % 4) + w];
      if (r != 10) begin
        for (int c = 0; c < 4; c++)
          for (int i = 0; i < 4; i++) begin
            s[4*c + i] = 8'h00;
            for (int j = 0; j < 4; j++) s[4*c + i] ^= gmul(m[(j - i) & 3], t[4*c + j]);
          end
      end else begin
        for (int k = 0; k < 16; k++) s[k] = t[k];
      end
      for (int k = 0; k < 16; k++) s[k] ^= rks[r][127 - 8*k -: 8];
    end
    for (int k = 0; k < 16; k++) o[127 - 8*k -: 8] = s[k];
    return o;
  endfunction

  task automatic run_block(input logic [127:0] p, input logic [127:0] exp_st0,
                           input logic [127:0] exp_st1, input logic [127:0] exp_ct,
                           input int stall);
    int t = 0;
    int j = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    check("in_ready_idle", 128'(in_ready), 128'(1));
    check("rk_idx_idle", 128'(rk_idx), 128'(0));
    in_valid = 1'b1;
    pt = p;
    @(negedge clk);
    in_valid = 1'b0;
    pt = {$urandom, $urandom, $urandom, $urandom};
    while (!out_valid && j < 20) begin
      check("rk_idx_round", 128'(rk_idx), 128'(j + 1));
      check("in_ready_busy", 128'(in_ready), 128'(0));
      if (j == 0) check("st_accept", dut.st, exp_st0);
      if (j == 1) check("st_round1", dut.st, exp_st1);
      @(negedge clk);
      j++;
    end
    check("latency", 128'(j + 1), 128'(11));
    check("ct", ct, exp_ct);
    check("rk_idx_done", 128'(rk_idx), 128'(0));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      pt = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check("ct_hold", ct, exp_ct);
      check("out_valid_hold", 128'(out_valid), 128'(1));
      check("in_ready_hold", 128'(in_ready), 128'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_release", 128'(out_valid), 128'(0));
    check("in_ready_release", 128'(in_ready), 128'(1));
  endtask

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] ST0_B = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] ST1_B = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] p;
    logic [127:0] exp_q [$];
    int           acc_t [$];
    int           n_out;
    int           t;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; pt = '0;
    build_sbox();
    set_key(KEY_B);
    repeat (2) @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_ct", ct, 128'(0));
    check("rst_rk_idx", 128'(rk_idx), 128'(0));
    rst = 1'b0;
    #1 check("post_rst_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk);

    // FIPS-197 App. B with backpressure, then App. C.1.
    run_block(PT_B, ST0_B, ST1_B, CT_B, 20);
    set_key(KEY_C);
    run_block(PT_C, PT_C ^ KEY_C, aes_ref(PT_C, 1), CT_C, 0);

    for (int n = 0; n < 4; n++) begin
      set_key({$urandom, $urandom, $urandom, $urandom});
      p = {$urandom, $urandom, $urandom, $urandom};
      run_block(p, aes_ref(p, 0), aes_ref(p, 1), aes_ref(p, 10), int'($urandom_range(0, 5)));
    end

    // Back-to-back with in_valid and out_ready held high.
    set_key({$urandom, $urandom, $urandom, $urandom});
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    pt = {$urandom, $urandom, $urandom, $urandom};
    n_out = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) check("b2b_ct", ct, exp_q.pop_front());
        n_out++;
      end
      if (in_valid && in_ready) begin
        acc_t.push_back(cyc);
        exp_q.push_back(aes_ref(pt, 10));
      end
      @(negedge clk);
      if (acc_t.size() > 0 && acc_t[$] == cyc) pt = {$urandom, $urandom, $urandom, $urandom};
    end
    in_valid = 1'b0;
    check("b2b_accepts", 128'(acc_t.size()), 128'(5));
    check("b2b_outputs", 128'(n_out), 128'(4));
    for (int i = 1; i < acc_t.size(); i++) check("b2b_spacing", 128'(acc_t[i] - acc_t[i-1]), 128'(12));
    t = 0;
    while (!in_ready && t < 20) begin @(negedge clk); t++; end
    check("b2b_drain", 128'(in_ready), 128'(1));
    out_ready = 1'b0;

    // Reset at round 5 abandons the block.
    set_key(KEY_B);
    in_valid = 1'b1;
    pt = PT_B;
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (rk_idx != 4'd5 && t < 20) begin @(negedge clk); t++; end
    check("reach_round5", 128'(rk_idx), 128'(5));
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 128'(in_ready), 128'(0));
    check("midrst_st", dut.st, 128'(0));
    rst = 1'b0;
    #1 check("midrst_in_ready_after", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("midrst_no_output", 128'(out_valid), 128'(0));
    end
    out_ready = 1'b0;

    // rst and in_valid at the same edge: nothing accepted.
    rst = 1'b1;
    in_valid = 1'b1;
    pt = PT_B;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_wins_st", dut.st, 128'(0));
    check("rst_wins_idle", 128'(in_ready), 128'(1));
    @(negedge clk);
    check("rst_wins_rk_idx", 128'(rk_idx), 128'(0));

    run_block(PT_B, ST0_B, ST1_B, CT_B, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
